// File: rtl/exec_mem_unit.sv
// Execute/memory stage datapath: ALU control decode, combinational 32-bit ALU,
// and a word-addressed data memory (async LW read, clocked SW write).
module exec_mem_unit #(
  parameter int DMEM_WORDS = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [5:0]  ex_op,
  input  logic [5:0]  ex_funct,
  input  logic [31:0] alu_a,
  input  logic [31:0] alu_b,
  output logic [2:0]  alu_ctrl,
  output logic [31:0] alu_result,
  output logic        alu_zero,
  input  logic [5:0]  mem_op,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam int AW = $clog2(DMEM_WORDS);

  // No handshake on any port: one ALU op and at most one memory access per cycle.

  always_comb begin
    alu_ctrl = ALU_ADD;
    case (ex_op)
      OP_LW, OP_SW, OP_ADDI: alu_ctrl = ALU_ADD;
      OP_BEQ:                alu_ctrl = ALU_SUB;
      OP_RTYPE: begin
        case (ex_funct)
          6'b100000: alu_ctrl = ALU_ADD;
          6'b100010: alu_ctrl = ALU_SUB;
          6'b100100: alu_ctrl = ALU_AND;
          6'b100101: alu_ctrl = ALU_OR;
          6'b100110: alu_ctrl = ALU_XOR;
          6'b100111: alu_ctrl = ALU_NOR;
          6'b101010: alu_ctrl = ALU_SLT;
          default:   alu_ctrl = ALU_ADD;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      ALU_AND: alu_result = alu_a & alu_b;
      ALU_OR:  alu_result = alu_a | alu_b;
      ALU_ADD: alu_result = alu_a + alu_b;
      ALU_XOR: alu_result = alu_a ^ alu_b;
      ALU_NOR: alu_result = ~(alu_a | alu_b);
      ALU_SUB: alu_result = alu_a - alu_b;
      ALU_SLT: alu_result = {31'b0, $signed(alu_a) < $signed(alu_b)};
      default: alu_result = '0;
    endcase
  end

  assign alu_zero = (alu_result == 32'h0);

  // Byte offset and bits above the memory size are dropped, so addresses wrap.
  logic [AW-1:0] mem_idx;
  logic [31:0]   mem [DMEM_WORDS];

  assign mem_idx = mem_addr[AW+1:2];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DMEM_WORDS; i++) mem[i] <= '0;
    end else if (mem_op == OP_SW) begin
      mem[mem_idx] <= mem_wdata;
    end
  end

  assign mem_rdata = (mem_op == OP_LW) ? mem[mem_idx] : 32'h0;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr[31:AW+2], mem_addr[1:0]};

endmodule

// File: tb/tb_exec_mem_unit.sv
// Randomized + directed bench for exec_mem_unit against a behavioural model
// of the ALU table and a word-array data memory.
module tb_exec_mem_unit;

  localparam int DMEM_WORDS = 1024;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_ADDI = 6'b001000,
                         OP_J = 6'b000010, OP_JAL = 6'b000011;
  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100,
                         F_OR = 6'b100101, F_XOR = 6'b100110, F_NOR = 6'b100111,
                         F_SLT = 6'b101010, F_JR = 6'b001000, F_NOP = 6'b000000;

  logic        clock = 1'b0;
  logic        reset;
  logic [5:0]  ex_op, ex_funct, mem_op;
  logic [31:0] alu_a, alu_b, mem_addr, mem_wdata;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_result, mem_rdata;
  logic        alu_zero;

  int n_vectors = 0;
  int n_miscompares = 0;
  logic [31:0] ref_mem [DMEM_WORDS];
  logic [31:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  exec_mem_unit #(.DMEM_WORDS(DMEM_WORDS)) dut (
    .clock(clock), .reset(reset),
    .ex_op(ex_op), .ex_funct(ex_funct), .alu_a(alu_a), .alu_b(alu_b),
    .alu_ctrl(alu_ctrl), .alu_result(alu_result), .alu_zero(alu_zero),
    .mem_op(mem_op), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // ---------------- reference model ----------------
  typedef enum {K_ADD, K_SUB, K_AND, K_OR, K_XOR, K_NOR, K_SLT} alu_kind_e;

  function automatic alu_kind_e ref_kind(input logic [5:0] op, input logic [5:0] fn);
    if (op == OP_BEQ) return K_SUB;
    if (op != OP_R) return K_ADD;
    if (fn == F_SUB) return K_SUB;
    if (fn == F_AND) return K_AND;
    if (fn == F_OR)  return K_OR;
    if (fn == F_XOR) return K_XOR;
    if (fn == F_NOR) return K_NOR;
    if (fn == F_SLT) return K_SLT;
    return K_ADD;
  endfunction

  function automatic logic [31:0] ref_ctrl(input alu_kind_e k);
    case (k)
      K_AND: return 32'd0;
      K_OR:  return 32'd1;
      K_XOR: return 32'd3;
      K_NOR: return 32'd4;
      K_SUB: return 32'd6;
      K_SLT: return 32'd7;
      default: return 32'd2;
    endcase
  endfunction

  function automatic logic [31:0] ref_alu(input alu_kind_e k, input logic [31:0] a, b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (k)
      K_SUB: return 32'(longint'(a) - longint'(b));
      K_AND: return a & b;
      K_OR:  return a | b;
      K_XOR: return a ^ b;
      K_NOR: return ~(a | b);
      K_SLT: return (sa < sb) ? 32'd1 : 32'd0;
      default: return 32'(longint'(a) + longint'(b));
    endcase
  endfunction

  function automatic int ref_index(input logic [31:0] addr);
    return int'((addr / 4) % DMEM_WORDS);
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [5:0] op, fn, input logic [31:0] a, b,
                       input logic [5:0] mop, input logic [31:0] addr, wd,
                       input logic rst);
    ex_op = op; ex_funct = fn; alu_a = a; alu_b = b;
    mem_op = mop; mem_addr = addr; mem_wdata = wd; reset = rst;
    exp_q.push_back((mop == OP_LW) ? ref_mem[ref_index(addr)] : 32'h0);
  endtask

  // Samples on the falling edge, between input changes and the next rising edge.
  task automatic settle_and_check();
    alu_kind_e k;
    logic [31:0] r;
    @(negedge clock);
    k = ref_kind(ex_op, ex_funct);
    r = ref_alu(k, alu_a, alu_b);
    check("alu_ctrl", {29'b0, alu_ctrl}, ref_ctrl(k));
    check("alu_result", alu_result, r);
    check("alu_zero", {31'b0, alu_zero}, (r == 32'h0) ? 32'd1 : 32'd0);
    if (exp_q.size() == 0) check("exp_q_empty", 32'd1, 32'd0);
    else check("mem_rdata", mem_rdata, exp_q.pop_front());
  endtask

  task automatic clock_edge();
    @(posedge clock);
    if (reset) begin
      for (int i = 0; i < DMEM_WORDS; i++) ref_mem[i] = 32'h0;
    end else if (mem_op == OP_SW) begin
      ref_mem[ref_index(mem_addr)] = mem_wdata;
    end
    #1;
  endtask

  task automatic cycle(input logic [5:0] op, fn, input logic [31:0] a, b,
                       input logic [5:0] mop, input logic [31:0] addr, wd,
                       input logic rst);
    drive(op, fn, a, b, mop, addr, wd, rst);
    settle_and_check();
    clock_edge();
  endtask

  // ---------------- stimulus ----------------
  logic [5:0] op_list [7];
  logic [5:0] fn_list [9];
  logic [31:0] edge_vals [6];

  initial begin
    op_list = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_JAL};
    fn_list = '{F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_JR, F_NOP};
    edge_vals = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h5};
    for (int i = 0; i < DMEM_WORDS; i++) ref_mem[i] = 32'h0;

    // Reset: ALU still live, mem_rdata zero with a non-LW op.
    drive(OP_R, F_ADD, 32'd3, 32'd4, OP_ADDI, 32'h10, 32'h0, 1'b1);
    @(negedge clock);
    check("rst_rdata", mem_rdata, exp_q.pop_front());
    check("rst_alu", alu_result, 32'd7);
    clock_edge();
    cycle(OP_R, F_ADD, 32'd0, 32'd0, OP_LW, 32'h0, 32'h0, 1'b1);

    // Decode sweep over every listed opcode and funct.
    foreach (op_list[i]) cycle(op_list[i], 6'h15, 32'd9, 32'd2, OP_LW, 32'h40, 32'h0, 1'b0);
    foreach (fn_list[i]) cycle(OP_R, fn_list[i], 32'd9, 32'd2, OP_J, 32'h40, 32'h0, 1'b0);
    drive(OP_LW, 6'h0, 32'd1, 32'd1, OP_ADDI, 32'h0, 32'h0, 1'b0);
    settle_and_check(); check("dec_lw", {29'b0, alu_ctrl}, 32'd2); clock_edge();
    drive(OP_BEQ, 6'h0, 32'd1, 32'd1, OP_ADDI, 32'h0, 32'h0, 1'b0);
    settle_and_check(); check("dec_beq", {29'b0, alu_ctrl}, 32'd6);
    check("beq_zero", {31'b0, alu_zero}, 32'd1); clock_edge();
    drive(OP_R, F_SLT, 32'd1, 32'd1, OP_ADDI, 32'h0, 32'h0, 1'b0);
    settle_and_check(); check("dec_slt", {29'b0, alu_ctrl}, 32'd7); clock_edge();

    // Arithmetic edges.
    drive(OP_R, F_ADD, 32'hFFFFFFFF, 32'd1, OP_J, 0, 0, 1'b0);
    settle_and_check(); check("add_wrap", alu_result, 32'h0);
    check("add_wrap_z", {31'b0, alu_zero}, 32'd1); clock_edge();
    drive(OP_R, F_SUB, 32'd5, 32'd7, OP_J, 0, 0, 1'b0);
    settle_and_check(); check("sub_neg", alu_result, 32'hFFFFFFFE); clock_edge();
    drive(OP_R, F_SLT, 32'h80000000, 32'd1, OP_J, 0, 0, 1'b0);
    settle_and_check(); check("slt_neg", alu_result, 32'd1); clock_edge();
    drive(OP_R, F_SLT, 32'd1, 32'h80000000, OP_J, 0, 0, 1'b0);
    settle_and_check(); check("slt_pos", alu_result, 32'd0); clock_edge();

    // Logic patterns.
    drive(OP_R, F_AND, 32'hF0F0F0F0, 32'h0FF00FF0, OP_J, 0, 0, 1'b0);
    settle_and_check(); check("and", alu_result, 32'h00F000F0); clock_edge();
    drive(OP_R, F_OR, 32'hF0F0F0F0, 32'h0FF00FF0, OP_J, 0, 0, 1'b0);
    settle_and_check(); check("or", alu_result, 32'hFFF0FFF0); clock_edge();
    drive(OP_R, F_XOR, 32'hF0F0F0F0, 32'h0FF00FF0, OP_J, 0, 0, 1'b0);
    settle_and_check(); check("xor", alu_result, 32'hFF00FF00); clock_edge();
    drive(OP_R, F_NOR, 32'hF0F0F0F0, 32'h0FF00FF0, OP_J, 0, 0, 1'b0);
    settle_and_check(); check("nor", alu_result, 32'h000F000F); clock_edge();

    // Store then load, alignment and wrap.
    cycle(OP_J, 0, 0, 0, OP_SW, 32'h10, 32'hDEADBEEF, 1'b0);
    drive(OP_J, 0, 0, 0, OP_LW, 32'h10, 0, 1'b0);
    settle_and_check(); check("ld_10", mem_rdata, 32'hDEADBEEF); clock_edge();
    drive(OP_J, 0, 0, 0, OP_LW, 32'h13, 0, 1'b0);
    settle_and_check(); check("ld_13", mem_rdata, 32'hDEADBEEF); clock_edge();
    drive(OP_J, 0, 0, 0, OP_LW, 32'h1010, 0, 1'b0);
    settle_and_check(); check("ld_wrap", mem_rdata, 32'hDEADBEEF); clock_edge();

    // Non-memory op neither reads nor writes.
    drive(OP_J, 0, 0, 0, OP_ADDI, 32'h10, 32'h12345678, 1'b0);
    settle_and_check(); check("addi_rd", mem_rdata, 32'h0); clock_edge();
    cycle(OP_J, 0, 0, 0, OP_LW, 32'h10, 0, 1'b0);

    // Store overwrites next edge; load must still see the old word this cycle.
    drive(OP_J, 0, 0, 0, OP_SW, 32'h10, 32'hCAFEF00D, 1'b0);
    settle_and_check(); clock_edge();
    drive(OP_J, 0, 0, 0, OP_LW, 32'h10, 0, 1'b0);
    settle_and_check(); check("ld_new", mem_rdata, 32'hCAFEF00D); clock_edge();
    drive(OP_J, 0, 0, 0, OP_SW, 32'h10, 32'h11111111, 1'b0);
    settle_and_check(); check("sw_cycle_rd", mem_rdata, 32'h0);
    mem_op = OP_LW; #1;
    check("old_before_edge", mem_rdata, 32'hCAFEF00D);
    mem_op = OP_SW;
    clock_edge();

    // Several words, then reset with a concurrent store.
    for (int i = 0; i < 4; i++) cycle(OP_J, 0, 0, 0, OP_SW, 32'h100 + 4 * i, 32'hA000 + i, 1'b0);
    cycle(OP_J, 0, 0, 0, OP_SW, 32'h200, 32'hBBBBBBBB, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(OP_J, 0, 0, 0, OP_LW, 32'h100 + 4 * i, 0, 1'b0);
      settle_and_check(); check("post_rst", mem_rdata, 32'h0); clock_edge();
    end
    drive(OP_J, 0, 0, 0, OP_LW, 32'h200, 0, 1'b0);
    settle_and_check(); check("rst_sw_drop", mem_rdata, 32'h0); clock_edge();
    drive(OP_J, 0, 0, 0, OP_LW, 32'h10, 0, 1'b0);
    settle_and_check(); check("rst_10", mem_rdata, 32'h0); clock_edge();

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      logic [5:0] op, fn, mop;
      logic [31:0] a, b, addr;
      logic rst;
      op = ($urandom_range(0, 7) == 7) ? 6'($urandom) : op_list[$urandom_range(0, 6)];
      fn = ($urandom_range(0, 5) == 5) ? 6'($urandom) : fn_list[$urandom_range(0, 8)];
      a = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 9) == 0) b = a;
      case ($urandom_range(0, 5))
        0, 1:    mop = OP_LW;
        2, 3:    mop = OP_SW;
        4:       mop = OP_ADDI;
        default: mop = 6'($urandom);
      endcase
      addr = ($urandom & 32'hFFFFF003) | (32'($urandom_range(0, 15)) << 2);
      rst = ($urandom_range(0, 99) == 0);
      cycle(op, fn, a, b, mop, addr, $urandom, rst);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
